uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
UART transmit controller. Accepts one data word per valid/ready handshake and serialises it LSB-first on a single line: start bit, DATA_W data bits, optional parity bit, STOP_BITS stop bits. Bit timing comes from an internal divide-by-DIV baud tick counter that this block enables, clears and sequences. It sits between the byte source (FIFO or test logic) and the FPGA TX pin.

Parameters:
DIV, 25, clock cycles per bit; legal range ≥2.
DATA_W, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
data  input  DATA_W  word to send; sampled only on handshake
valid  input  1  source has a word
ready  output  1  controller can accept; high only in IDLE
tx  output  1  serial line, registered, idle high
busy  output  1  high from the cycle after acceptance until the frame ends

Behaviour:
- Reset (rst low, any time, asynchronous): state=IDLE, tx=1, ready=1, busy=0, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts the frame; tx returns high immediately.
- Handshake: accept when valid && ready at a rising edge. Latch data into the shift register, compute parity over the latched data, clear the baud counter, go to START. ready drops in the same edge. valid with ready low is ignored; the source holds it.
- Baud counter: runs 0..DIV-1 while state≠IDLE. Tick = (count==DIV-1). The counter wraps to 0 on tick. Every bit lasts exactly DIV cycles.
- States and transitions (all advance only on tick):
  - IDLE: tx=1.
  - START: tx=0. Goes to DATA with bit index=0.
  - DATA: tx=shift[0]. Shift right on tick. Increment the index. After bit DATA_W-1, go to PARITY if PARITY≠0, else STOP.
  - PARITY: tx=parity bit. Odd mode: ^data ^1. Even mode: ^data. Goes to STOP.
  - STOP: tx=1 for STOP_BITS×DIV cycles, using the bit index as the stop counter. Then goes to IDLE, ready=1, busy=0.
- tx is registered. The first start-bit cycle is the cycle after the accepting edge, so latency from handshake to tx falling is 1 cycle.
- Frame length F = (1 + DATA_W + (PARITY≠0) + STOP_BITS)×DIV cycles.
- IDLE lasts at least 1 cycle between frames. With valid held high, consecutive start bits are F+1 cycles apart.
- Illegal parameter values are a synthesis-time error (elaboration check). They have no run-time behaviour.

Test Plan:
- Reset then idle: rst low 3 cycles, then high for 50 cycles with valid=0 → tx=1, ready=1, busy=0 throughout.
- Single frame, defaults: send 0xA5 → tx low 25 cycles, then bits 1,0,1,0,0,1,0,1 at 25 cycles each, then high 25 cycles. ready is low for exactly 250 cycles.
- Parity: PARITY=2 with 0x07, then PARITY=1 with 0x07 → parity bit is 1 (even) and 0 (odd). Frame is 275 cycles.
- Back-to-back: valid held high with 0x00 then 0xFF, STOP_BITS=2 → second start bit falls 276 cycles after the first. Both frames decode correctly and no extra word is accepted.
- Reset mid-frame: assert rst during data bit 3 → tx=1 and ready=1 asynchronously. After release, a new send of 0x3C produces a clean full frame.
- Ignored valid: pulse valid for 1 cycle while busy → no acceptance, and the current frame is unchanged.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// UART transmit controller. It accepts one word per valid/ready handshake and
// sends it LSB-first on a single line: one start bit, DATA_W data bits, an
// optional parity bit, then STOP_BITS stop bits. Each bit lasts DIV clock
// cycles, timed by an internal baud counter that runs only while a frame is
// in flight.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   data   in   word to send, sampled only on the accepting edge
//   valid  in   source has a word
//   ready  out  controller can accept (high only while idle)
//   tx     out  registered serial line, idles high
//   busy   out  high from the cycle after acceptance until the frame ends
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DIV       = 25,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    // Illegal parameters stop elaboration; there is no run-time fallback.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_ctrl: DIV must be >= 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_ctrl: DATA_W must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_ctrl: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(DIV);
    // Wide enough for both the data bit index and the stop bit count.
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q,   par_d;
    logic                tx_q,    tx_d;
    logic                tick;

    // End of the current bit period.
    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // NOTE: every variable gets a default before the case statement so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;

        // Baud counter free-runs 0..DIV-1 for the whole frame.
        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    shift_d = data;
                    // Odd mode inverts the XOR reduction so the total count
                    // of ones including the parity bit is odd.
                    par_d   = (PARITY == 1) ? ~(^data) : ^data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // The bit index doubles as the stop bit counter.
                if (tick) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered;
        // that puts the start bit on the line one cycle after acceptance.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    // NOTE: all state registers are reset, including the shift register, so
    // an aborted frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign tx    = tx_q;

endmodule
